led_frame_writer: RTL and testbench
===================================

// Module: led_frame_writer
// PURPOSE
//  Upstream feeder for the 4820 LED serializer. Holds an 8-byte shadow frame (one byte per
//  driver chip) written by the host. Schedules one serializer transaction per changed byte:
//  DataOut/AddressOut plus a 1-cycle WRITEOut strobe, then a fixed guard gap covering the
//  serializer's 8-bit / 1 MHz shift. Also sequences the chip CLEAR line.
// PARAMETERS
//  GAP_CYCLES      420         cycles from WRITEOut to next strobe; >= 8*50+2 serializer cycles
//  CLEAR_CYCLES    4           cycles CLEAROut is held high per clear request
//  REFRESH_CYCLES  50_000_000  period of forced full-frame rewrite (PERIODIC_REFRESH_EN only)
// PORTS
//  SysClk      in   1  system clock, 50 MHz
//  SysRst      in   1  reset; synchronous, active-high
//  HostWrEn    in   1  host write strobe; one byte per cycle
//  HostAddr    in   3  chip index 0..7 for HostData
//  HostData    in   8  segment byte for chip HostAddr
//  ClearReq    in   1  request chip clear + shadow zero (level or pulse; edge not required)
//  DataOut     out  8  byte to serializer; stable from WRITEOut through end of GAP
//  AddressOut  out  4  serializer address; bit3 always 0, [2:0] = chip index
//  WRITEOut    out  1  1-cycle write strobe to serializer
//  CLEAROut    out  1  chip clear, high for CLEAR_CYCLES
//  Busy        out  1  high when state != IDLE or any dirty bit set
// BEHAVIOUR
//  Reset: shadow=0, dirty=8'h00, rr_ptr=0, DataOut=0, AddressOut=0, WRITEOut=0, CLEAROut=0,
//   Busy=0, state=IDLE. Reset mid-transaction abandons the strobe/gap; the serializer finishes alone.
//  Host write: shadow[HostAddr]<=HostData, dirty[HostAddr]<=1, accepted in every state.
//   Exception: the cycle a clear is accepted, the host write is dropped.
//  FSM states: IDLE, STROBE, GAP, CLEAR.
//   IDLE: pending clear -> CLEAR (priority). Else any dirty -> pick the first dirty index at or
//    after rr_ptr, wrapping 7->0. Latch DataOut=shadow[idx] and AddressOut={1'b0,idx}.
//    Clear dirty[idx], set rr_ptr=idx+1 mod 8, go to STROBE.
//   STROBE: WRITEOut=1 for exactly this cycle; gap counter loaded GAP_CYCLES-1; -> GAP.
//   GAP: count down to 0, then -> IDLE. DataOut/AddressOut are held unchanged.
//   CLEAR: CLEAROut=1 for CLEAR_CYCLES cycles, then -> IDLE.
//    On entry: shadow<=0, dirty<=0, pending-clear<=0.
//  Latency: host write while IDLE, no other dirty bit set -> WRITEOut on cycle +2.
//  Dirty set and cleared in the same cycle (host rewrites the byte being picked): set wins.
//   The byte is re-sent next round with the new data.
//  ClearReq outside IDLE: latched as pending; executed on the next IDLE cycle, ahead of dirty bytes.
//  Back-to-back strobes are separated by exactly GAP_CYCLES+1 cycles (GAP + IDLE pick).
//  Counter widths: $clog2(max(GAP_CYCLES, CLEAR_CYCLES)+1); no wrap is allowed in any counter.
// CONFIGURATION
//  PERIODIC_REFRESH_EN defined: free-running counter of REFRESH_CYCLES.
//   At terminal count it ORs dirty with 8'hFF, rewriting all chips; a refresh colliding with a
//   clear entry is discarded.
//  Undefined: no refresh counter exists; only host-dirtied bytes are sent.
// STRUCTURE
//  led_frame_pkg: FSM state encoding, CHIP_CNT=8, CHIP_AW=3, ADDR_OUT_W=4, default GAP/CLEAR
//   constants.
//  Sub-module led_rr_pick: combinational round-robin first-set finder.
//   Inputs: dirty[7:0], rr_ptr[2:0]. Outputs: idx[2:0], any.
// TESTING
//  1 Reset, then HostWrEn addr=3 data=8'hA5 -> WRITEOut 2 cycles later, DataOut=A5,
//    AddressOut=4'h3; Busy falls after the gap.
//  2 Write addrs 7,0,1 in consecutive cycles while IDLE -> strobes in order 7,0,1, spaced
//    GAP_CYCLES+1 apart.
//  3 Rewrite addr 2 with 8'h3C during its GAP -> addr 2 is sent twice; the second DataOut=3C.
//  4 ClearReq during a GAP with addr 5 dirty -> CLEAROut high 4 cycles after the gap, and
//    addr 5 is never sent.
//  5 SysRst asserted mid-GAP -> all outputs 0 next cycle, dirty=0, no further strobe.
//  6 PERIODIC_REFRESH_EN, REFRESH_CYCLES=2000 -> 8 strobes, addrs 0..7, after the terminal count.

Source files
------------

// File: rtl/led_frame_pkg.sv
// rtl/led_frame_pkg.sv - shared constants, FSM encoding and helpers for the LED frame writer
package led_frame_pkg;

    localparam int CHIP_CNT         = 8;
    localparam int CHIP_AW          = 3;
    localparam int ADDR_OUT_W       = 4;
    localparam int DEF_GAP_CYCLES   = 420;
    localparam int DEF_CLEAR_CYCLES = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STROBE,
        ST_GAP,
        ST_CLEAR
    } frameState_t;

    function automatic int maxInt(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/led_rr_pick.sv
// rtl/led_rr_pick.sv - combinational round-robin finder: first dirty chip at or after RrPtr
import led_frame_pkg::*;

module led_rr_pick (
    input  logic [CHIP_CNT-1:0] Dirty,
    input  logic [CHIP_AW-1:0]  RrPtr,
    output logic [CHIP_AW-1:0]  Idx,
    output logic                Any
);

    logic [CHIP_AW-1:0] cand;

    // Walk offsets from farthest to nearest so the closest hit overwrites the others.
    always_comb begin
        Idx  = '0;
        Any  = 1'b0;
        cand = '0;
        for (int i = CHIP_CNT - 1; i >= 0; i--) begin
            cand = RrPtr + CHIP_AW'(i);
            if (Dirty[cand]) begin
                Idx = cand;
                Any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/led_frame_writer.sv
// rtl/led_frame_writer.sv - shadow frame + serializer write scheduler; optional PERIODIC_REFRESH_EN
import led_frame_pkg::*;

module led_frame_writer #(
    parameter int GAP_CYCLES   = DEF_GAP_CYCLES,
    parameter int CLEAR_CYCLES = DEF_CLEAR_CYCLES
`ifdef PERIODIC_REFRESH_EN
    ,
    parameter int REFRESH_CYCLES = 50_000_000
`endif
) (
    input  logic                  SysClk,
    input  logic                  SysRst,
    input  logic                  HostWrEn,
    input  logic [CHIP_AW-1:0]    HostAddr,
    input  logic [7:0]            HostData,
    input  logic                  ClearReq,
    output logic [7:0]            DataOut,
    output logic [ADDR_OUT_W-1:0] AddressOut,
    output logic                  WRITEOut,
    output logic                  CLEAROut,
    output logic                  Busy
);

    localparam int CNT_W = $clog2(maxInt(GAP_CYCLES, CLEAR_CYCLES) + 1);

    frameState_t         state;
    logic [7:0]          shadow [CHIP_CNT];
    logic [CHIP_CNT-1:0] dirty;
    logic [CHIP_CNT-1:0] dirtyNext;
    logic [CHIP_AW-1:0]  rrPtr;
    logic [CHIP_AW-1:0]  pickIdx;
    logic                pickAny;
    logic                pickFire;
    logic                clearPend;
    logic                clearEntry;
    logic                refreshHit;
    logic [CNT_W-1:0]    cnt;

    led_rr_pick uPick (
        .Dirty (dirty),
        .RrPtr (rrPtr),
        .Idx   (pickIdx),
        .Any   (pickAny)
    );

`ifdef PERIODIC_REFRESH_EN
    localparam int REF_W = $clog2(REFRESH_CYCLES);

    logic [REF_W-1:0] refreshCnt;

    assign refreshHit = (refreshCnt == REF_W'(REFRESH_CYCLES - 1));

    always_ff @(posedge SysClk) begin
        if (SysRst || refreshHit) begin
            refreshCnt <= '0;
        end else begin
            refreshCnt <= refreshCnt + 1'b1;
        end
    end
`else
    assign refreshHit = 1'b0;
`endif

    assign clearEntry = (state == ST_IDLE) && (clearPend || ClearReq);
    assign pickFire   = (state == ST_IDLE) && !clearEntry && pickAny;
    assign Busy       = (state != ST_IDLE) || (|dirty);

    // A host write landing on the byte being picked re-dirties it; a clear entry wipes everything.
    always_comb begin
        dirtyNext = dirty;
        if (pickFire) begin
            dirtyNext[pickIdx] = 1'b0;
        end
        if (refreshHit) begin
            dirtyNext = '1;
        end
        if (HostWrEn) begin
            dirtyNext[HostAddr] = 1'b1;
        end
        if (clearEntry) begin
            dirtyNext = '0;
        end
    end

    always_ff @(posedge SysClk) begin
        if (SysRst) begin
            state      <= ST_IDLE;
            dirty      <= '0;
            rrPtr      <= '0;
            clearPend  <= 1'b0;
            cnt        <= '0;
            DataOut    <= '0;
            AddressOut <= '0;
            WRITEOut   <= 1'b0;
            CLEAROut   <= 1'b0;
            for (int i = 0; i < CHIP_CNT; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            dirty <= dirtyNext;
            if (clearEntry) begin
                for (int i = 0; i < CHIP_CNT; i++) begin
                    shadow[i] <= '0;
                end
            end else if (HostWrEn) begin
                shadow[HostAddr] <= HostData;
            end
            if ((state != ST_IDLE) && ClearReq) begin
                clearPend <= 1'b1;
            end

            // The strobe cycle is the first gap cycle, so strobes sit GAP_CYCLES+1 apart.
            case (state)
                ST_IDLE: begin
                    if (clearEntry) begin
                        clearPend <= 1'b0;
                        CLEAROut  <= 1'b1;
                        cnt       <= CNT_W'(CLEAR_CYCLES - 1);
                        state     <= ST_CLEAR;
                    end else if (pickAny) begin
                        DataOut    <= shadow[pickIdx];
                        AddressOut <= {{(ADDR_OUT_W - CHIP_AW){1'b0}}, pickIdx};
                        rrPtr      <= pickIdx + 1'b1;
                        WRITEOut   <= 1'b1;
                        cnt        <= CNT_W'(GAP_CYCLES - 1);
                        state      <= ST_STROBE;
                    end
                end
                ST_STROBE: begin
                    WRITEOut <= 1'b0;
                    cnt      <= cnt - 1'b1;
                    state    <= ST_GAP;
                end
                ST_GAP: begin
                    if (cnt == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (cnt == '0) begin
                        CLEAROut <= 1'b0;
                        state    <= ST_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_led_frame_writer.sv
// tb/tb_led_frame_writer.sv - directed and randomized bench for led_frame_writer
module tb_led_frame_writer;

    localparam int GAP     = 420;
    localparam int CLR     = 4;
    localparam int REFRESH = 2000;

    logic       SysClk = 1'b0;
    logic       SysRst = 1'b1;
    logic       HostWrEn = 1'b0;
    logic [2:0] HostAddr = '0;
    logic [7:0] HostData = '0;
    logic       ClearReq = 1'b0;
    logic [7:0] DataOut;
    logic [3:0] AddressOut;
    logic       WRITEOut;
    logic       CLEAROut;
    logic       Busy;

    int passCnt  = 0;
    int totalCnt = 0;
    int failCnt  = 0;
    int cyc      = 0;

    int   stCyc[$];
    int   stAddr[$];
    int   stData[$];
    int   clrStart[$];
    int   clrWidth[$];
    int   clrRun = 0;
    logic clrPrev = 1'b0;
    int   addrHiErr = 0;

    logic [7:0] chipView [8];
    logic [7:0] mShadow [8];

`ifdef PERIODIC_REFRESH_EN
    led_frame_writer #(.GAP_CYCLES(GAP), .CLEAR_CYCLES(CLR), .REFRESH_CYCLES(REFRESH)) dut (
`else
    led_frame_writer #(.GAP_CYCLES(GAP), .CLEAR_CYCLES(CLR)) dut (
`endif
        .SysClk     (SysClk),
        .SysRst     (SysRst),
        .HostWrEn   (HostWrEn),
        .HostAddr   (HostAddr),
        .HostData   (HostData),
        .ClearReq   (ClearReq),
        .DataOut    (DataOut),
        .AddressOut (AddressOut),
        .WRITEOut   (WRITEOut),
        .CLEAROut   (CLEAROut),
        .Busy       (Busy)
    );

    always #10 SysClk = ~SysClk;

    always @(posedge SysClk) cyc <= cyc + 1;

    // Serializer-side observer: what each chip currently holds, plus strobe/clear timing.
    always @(negedge SysClk) begin
        if (WRITEOut) begin
            stCyc.push_back(cyc);
            stAddr.push_back(int'(AddressOut[2:0]));
            stData.push_back(int'(DataOut));
            chipView[AddressOut[2:0]] = DataOut;
            if (AddressOut[3]) addrHiErr++;
        end
        if (CLEAROut && !clrPrev) begin
            clrStart.push_back(cyc);
            clrRun = 1;
            for (int i = 0; i < 8; i++) chipView[i] = 8'h00;
        end else if (CLEAROut) begin
            clrRun++;
        end
        if (!CLEAROut && clrPrev) clrWidth.push_back(clrRun);
        clrPrev = CLEAROut;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        totalCnt++;
        assert (obs === exp) passCnt++;
        else begin
            failCnt++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge SysClk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic hostWrite(input logic [2:0] a, input logic [7:0] d, output int wc);
        HostWrEn = 1'b1;
        HostAddr = a;
        HostData = d;
        wc = cyc;
        mShadow[a] = d;
        tick();
        HostWrEn = 1'b0;
    endtask

    task automatic waitStrobes(input int n, input int budget);
        for (int k = 0; k < budget && stCyc.size() < n; k++) tick();
    endtask

    task automatic waitIdle(input int budget);
        for (int k = 0; k < budget && Busy; k++) tick();
    endtask

    task automatic clearLog();
        stCyc.delete();
        stAddr.delete();
        stData.delete();
        clrStart.delete();
        clrWidth.delete();
    endtask

    function automatic logic [63:0] packArr(input logic [7:0] a [8]);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[i*8 +: 8] = a[i];
        return r;
    endfunction

    initial begin
        int wc;
        int t0;
        int nWr;
        int bad;
        for (int i = 0; i < 8; i++) begin
            chipView[i] = 8'h00;
            mShadow[i]  = 8'h00;
        end

        SysRst = 1'b1;
        ticks(3);
        SysRst = 1'b0;
        check("rst_data", DataOut, 8'h00);
        check("rst_addr", AddressOut, 4'h0);
        check("rst_write_clear_busy", {WRITEOut, CLEAROut, Busy}, 3'b000);
        tick();

`ifdef PERIODIC_REFRESH_EN
        t0 = cyc;
        clearLog();
        waitStrobes(8, REFRESH + 8 * (GAP + 1) + 200);
        check("ref_count", stCyc.size(), 8);
        if (stCyc.size() >= 8) begin
            check("ref_first_after_tc", (stCyc[0] >= t0 + REFRESH - 4) && (stCyc[0] <= t0 + REFRESH + 4), 1);
            for (int i = 0; i < 8; i++) begin
                check($sformatf("ref_addr%0d", i), stAddr[i], i);
                check($sformatf("ref_data%0d", i), stData[i], 0);
            end
            check("ref_spacing", stCyc[7] - stCyc[0], 7 * (GAP + 1));
        end
`else
        // Single write: latency, content, Busy release
        clearLog();
        hostWrite(3'd3, 8'hA5, wc);
        waitStrobes(1, 20);
        check("t1_count", stCyc.size(), 1);
        if (stCyc.size() >= 1) begin
            t0 = stCyc[0];
            check("t1_latency", t0 - wc, 2);
            check("t1_data", stData[0], 8'hA5);
            check("t1_addr", stAddr[0], 3);
            waitIdle(GAP + 20);
            check("t1_busy_fall", cyc - t0, GAP);
        end

        // Three consecutive writes while idle
        tick();
        clearLog();
        hostWrite(3'd7, 8'h77, wc);
        hostWrite(3'd0, 8'h10, wc);
        hostWrite(3'd1, 8'h21, wc);
        waitStrobes(3, 4 * (GAP + 1));
        check("t2_count", stCyc.size(), 3);
        if (stCyc.size() >= 3) begin
            check("t2_order", {stAddr[0][7:0], stAddr[1][7:0], stAddr[2][7:0]}, 24'h070001);
            check("t2_data", {stData[0][7:0], stData[1][7:0], stData[2][7:0]}, 24'h771021);
            check("t2_space01", stCyc[1] - stCyc[0], GAP + 1);
            check("t2_space12", stCyc[2] - stCyc[1], GAP + 1);
        end
        waitIdle(GAP + 20);

        // Rewrite during own gap
        tick();
        clearLog();
        hostWrite(3'd2, 8'h81, wc);
        waitStrobes(1, 20);
        ticks(10);
        hostWrite(3'd2, 8'h3C, wc);
        waitStrobes(2, 2 * (GAP + 1));
        check("t3_count", stCyc.size(), 2);
        if (stCyc.size() >= 2) begin
            check("t3_addr2", stAddr[1], 2);
            check("t3_data2", stData[1], 8'h3C);
            check("t3_space", stCyc[1] - stCyc[0], GAP + 1);
        end
        waitIdle(GAP + 20);

        // Clear requested during a gap with another byte dirty
        tick();
        clearLog();
        hostWrite(3'd2, 8'h11, wc);
        waitStrobes(1, 20);
        t0 = (stCyc.size() > 0) ? stCyc[0] : cyc;
        ticks(5);
        hostWrite(3'd5, 8'h55, wc);
        ClearReq = 1'b1;
        tick();
        ClearReq = 1'b0;
        for (int i = 0; i < 8; i++) mShadow[i] = 8'h00;
        for (int k = 0; k < GAP + 40 && clrWidth.size() < 1; k++) tick();
        check("t4_clr_seen", clrWidth.size(), 1);
        if (clrWidth.size() >= 1) begin
            check("t4_clr_start", clrStart[0] - t0, GAP + 1);
            check("t4_clr_width", clrWidth[0], CLR);
        end
        ticks(2 * GAP);
        check("t4_no_addr5", stCyc.size(), 1);
        check("t4_busy", Busy, 1'b0);

        // Reset mid-gap
        clearLog();
        hostWrite(3'd4, 8'h44, wc);
        hostWrite(3'd6, 8'h66, wc);
        waitStrobes(1, 20);
        ticks(100);
        SysRst = 1'b1;
        tick();
        SysRst = 1'b0;
        for (int i = 0; i < 8; i++) mShadow[i] = 8'h00;
        check("t5_outs", {DataOut, AddressOut, WRITEOut, CLEAROut, Busy}, 15'h0);
        ticks(2 * GAP + 10);
        check("t5_no_strobe", stCyc.size(), 1);

        // Idle clear brings chips and model back to a known frame
        clearLog();
        ClearReq = 1'b1;
        tick();
        ClearReq = 1'b0;
        ticks(CLR + 4);
        check("clr_idle_width", (clrWidth.size() == 1) ? clrWidth[0] : -1, CLR);

        // Random bursts: after quiescence each chip must hold the last byte written to it
        for (int r = 0; r < 6; r++) begin
            clearLog();
            nWr = $urandom_range(1, 5);
            for (int w = 0; w < nWr; w++) begin
                hostWrite(3'($urandom_range(0, 7)), 8'($urandom), wc);
                ticks($urandom_range(0, 30));
            end
            waitIdle(15000);
            check($sformatf("rnd%0d_idle", r), Busy, 1'b0);
            check($sformatf("rnd%0d_frame", r), packArr(chipView), packArr(mShadow));
            check($sformatf("rnd%0d_strobes_le_writes", r), stCyc.size() <= nWr, 1);
            bad = 0;
            for (int i = 1; i < stCyc.size(); i++) begin
                if (stCyc[i] - stCyc[i-1] < GAP + 1) bad++;
            end
            check($sformatf("rnd%0d_spacing", r), bad, 0);
            tick();
        end
`endif
        check("addr_bit3_zero", addrHiErr, 0);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
